// File: rtl/adder_unit.sv
// adder_unit
//   Parameterized carry-lookahead adder. Bits are split into groups of BLOCK
//   bits. Each group resolves its internal carries by lookahead, and group
//   carries ripple from one group to the next. A combinational sum is
//   available at once, and a one-cycle registered copy carries the
//   carry/overflow flags.
//
// Ports
//   clk        : system clock (rising edge)
//   rst        : synchronous, active-high reset
//   a, b       : operands, WIDTH bits
//   in_valid   : capture the current sum into the registered outputs
//   result     : combinational (a + b) mod 2^WIDTH
//   out_valid  : registered outputs hold a freshly captured sum
//   result_q   : registered sum
//   carry_q    : registered unsigned carry-out
//   overflow_q : registered two's-complement overflow
module adder_unit #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic [WIDTH-1:0] result_q,
  output logic             carry_q,
  output logic             overflow_q
);

  localparam int NG = (WIDTH + BLOCK - 1) / BLOCK;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic             carry_out;
  logic             carry_msb;   // carry into bit WIDTH-1
  logic             overflow;

  assign g = a & b;
  assign p = a ^ b;

  // Carry out of bit j of a group, written as a flat sum of products:
  //   gg[j] | pp[j]gg[j-1] | ... | pp[j..0]cin
  function automatic logic la_carry(input logic [BLOCK-1:0] gg,
                                    input logic [BLOCK-1:0] pp,
                                    input logic             cin,
                                    input int               j);
    logic term;
    logic acc;
    acc = 1'b0;
    for (int m = 0; m < BLOCK; m++) begin
      if (m <= j) begin
        term = gg[m];
        for (int n = m + 1; n < BLOCK; n++) begin
          if (n <= j) term = term & pp[n];
        end
        acc = acc | term;
      end
    end
    term = cin;
    for (int n = 0; n < BLOCK; n++) begin
      if (n <= j) term = term & pp[n];
    end
    return acc | term;
  endfunction

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int BASE = k * BLOCK;
    localparam int LEN  = ((WIDTH - BASE) < BLOCK) ? (WIDTH - BASE) : BLOCK;

    logic [BLOCK-1:0] gg;
    logic [BLOCK-1:0] pp;
    logic             cin;
    logic             cout;
    logic             grp_g;
    logic             grp_p;
    logic [LEN-1:0]   cbit;

    // Partial top group: unused upper lanes are zero, so they never generate.
    assign gg = BLOCK'(g[BASE +: LEN]);
    assign pp = BLOCK'(p[BASE +: LEN]);

    if (k == 0) begin : g_cin0
      assign cin = 1'b0;
    end else begin : g_cinr
      assign cin = g_grp[k-1].cout;
    end

    assign grp_g = la_carry(gg, pp, 1'b0, LEN - 1);
    assign grp_p = &pp[LEN-1:0];
    assign cout  = grp_g | (grp_p & cin);

    // Every internal carry depends only on the group carry-in.
    assign cbit[0] = cin;
    for (genvar j = 1; j < LEN; j++) begin : g_bit
      assign cbit[j] = la_carry(gg, pp, cin, j - 1);
    end

    assign result[BASE +: LEN] = pp[LEN-1:0] ^ cbit;

    if (k == NG - 1) begin : g_top
      assign carry_out = cout;
      assign carry_msb = cbit[LEN-1];
    end
  end

  assign overflow = carry_out ^ carry_msb;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result_q   <= result;
        carry_q    <= carry_out;
        overflow_q <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_adder_unit.sv
// tb_adder_unit
//   Directed bench for adder_unit: an 8-bit instance with 4-bit groups, a
//   13-bit instance with 4-bit groups (partial top group) and a 1-bit
//   instance. Expected values are hand-computed constants or come from a
//   plain '+' reference.
module tb_adder_unit;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;

  logic [7:0]  a8 = '0, b8 = '0, res8, resq8;
  logic        ov8, cq8, oq8;
  logic [12:0] a13 = '0, b13 = '0, res13, resq13;
  logic        ov13, cq13, oq13;
  logic [0:0]  a1 = '0, b1 = '0, res1, resq1;
  logic        ov1, cq1, oq1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = clk_run ? ~clk : 1'b0;

  adder_unit #(.WIDTH(8), .BLOCK(4)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
    .result(res8), .out_valid(ov8), .result_q(resq8),
    .carry_q(cq8), .overflow_q(oq8));

  adder_unit #(.WIDTH(13), .BLOCK(4)) u13 (
    .clk(clk), .rst(rst), .a(a13), .b(b13), .in_valid(in_valid),
    .result(res13), .out_valid(ov13), .result_q(resq13),
    .carry_q(cq13), .overflow_q(oq13));

  adder_unit #(.WIDTH(1), .BLOCK(1)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid),
    .result(res1), .out_valid(ov1), .result_q(resq1),
    .carry_q(cq1), .overflow_q(oq1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [12:0] corner [3];
    logic [13:0] s13;
    logic [1:0]  s1;
    logic [8:0]  s8;

    corner[0] = 13'h0000;
    corner[1] = 13'h1FFF;
    corner[2] = 13'h1000;

    // Exhaustive combinational sweep with the clock stopped.
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        a8 = 8'(i);
        b8 = 8'(j);
        #1;
        s8 = 9'(i) + 9'(j);
        chk("sweep_result", 64'(res8), 64'(s8[7:0]));
      end
    end

    // Reset state.
    clk_run = 1'b1;
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst_result_q", 64'(resq8), 64'h00);
    chk("rst_carry_q", 64'(cq8), 64'h0);
    chk("rst_overflow_q", 64'(oq8), 64'h0);
    chk("rst_out_valid", 64'(ov8), 64'h0);
    rst = 1'b0;

    // Wrap and carry.
    a8 = 8'hFF; b8 = 8'h01; in_valid = 1'b1;
    #1;
    chk("wrap_result", 64'(res8), 64'h00);
    tick();
    chk("wrap_result_q", 64'(resq8), 64'h00);
    chk("wrap_carry_q", 64'(cq8), 64'h1);
    chk("wrap_overflow_q", 64'(oq8), 64'h0);
    chk("wrap_out_valid", 64'(ov8), 64'h1);

    // Signed overflow, positive then negative.
    a8 = 8'h7F; b8 = 8'h01;
    tick();
    chk("ovp_result_q", 64'(resq8), 64'h80);
    chk("ovp_carry_q", 64'(cq8), 64'h0);
    chk("ovp_overflow_q", 64'(oq8), 64'h1);
    a8 = 8'h80; b8 = 8'h80;
    tick();
    chk("ovn_result_q", 64'(resq8), 64'h00);
    chk("ovn_carry_q", 64'(cq8), 64'h1);
    chk("ovn_overflow_q", 64'(oq8), 64'h1);
    chk("ovn_out_valid", 64'(ov8), 64'h1);

    // Hold when in_valid drops.
    a8 = 8'h12; b8 = 8'h34;
    tick();
    chk("hold_cap_result_q", 64'(resq8), 64'h46);
    chk("hold_cap_out_valid", 64'(ov8), 64'h1);
    in_valid = 1'b0; a8 = 8'h55;
    #1;
    chk("hold_result_now", 64'(res8), 64'h89);
    tick();
    chk("hold_result_q", 64'(resq8), 64'h46);
    chk("hold_carry_q", 64'(cq8), 64'h0);
    chk("hold_out_valid", 64'(ov8), 64'h0);
    chk("hold_result", 64'(res8), 64'h89);

    // Reset mid-stream wins over in_valid.
    a8 = 8'hC0; b8 = 8'hC0; in_valid = 1'b1;
    tick();
    chk("pre_rst_result_q", 64'(resq8), 64'h80);
    chk("pre_rst_carry_q", 64'(cq8), 64'h1);
    chk("pre_rst_overflow_q", 64'(oq8), 64'h0);
    a8 = 8'h40; b8 = 8'h41; rst = 1'b1;
    tick();
    chk("mid_rst_result_q", 64'(resq8), 64'h00);
    chk("mid_rst_carry_q", 64'(cq8), 64'h0);
    chk("mid_rst_overflow_q", 64'(oq8), 64'h0);
    chk("mid_rst_out_valid", 64'(ov8), 64'h0);
    chk("mid_rst_result", 64'(res8), 64'h81);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_out_valid", 64'(ov8), 64'h0);
    chk("post_rst_result_q", 64'(resq8), 64'h00);
    in_valid = 1'b1;
    tick();
    chk("post_rst_new_result_q", 64'(resq8), 64'h81);
    chk("post_rst_new_out_valid", 64'(ov8), 64'h1);

    // Partial group (13/4) and single-bit (1/1) against a '+' reference.
    for (int i = 0; i < 29; i++) begin
      if (i < 9) begin
        a13 = corner[i / 3];
        b13 = corner[i % 3];
      end else begin
        a13 = 13'($urandom_range(0, 8191));
        b13 = 13'($urandom_range(0, 8191));
      end
      a1 = 1'(i & 1);
      b1 = 1'((i >> 1) & 1);
      s13 = {1'b0, a13} + {1'b0, b13};
      s1  = {1'b0, a1} + {1'b0, b1};
      #1;
      chk("w13_result", 64'(res13), 64'(s13[12:0]));
      chk("w1_result", 64'(res1), 64'(s1[0]));
      tick();
      chk("w13_result_q", 64'(resq13), 64'(s13[12:0]));
      chk("w13_carry_q", 64'(cq13), 64'(s13[13]));
      chk("w13_overflow_q", 64'(oq13),
          64'((a13[12] == b13[12]) && (s13[12] != a13[12])));
      chk("w13_out_valid", 64'(ov13), 64'h1);
      chk("w1_result_q", 64'(resq1), 64'(s1[0]));
      chk("w1_carry_q", 64'(cq1), 64'(s1[1]));
      chk("w1_overflow_q", 64'(oq1), 64'(a1 & b1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
